// File: rtl/dh_key_agreement.sv
// Diffie-Hellman key-agreement sequencer.
// Draws a private exponent, asks the exponentiation unit for G^a mod P and
// then B^a mod P, validates the peer key and wipes the private key when done.
module dh_key_agreement #(
  parameter int unsigned  N          = 8,
  parameter logic [N-1:0] P          = 8'd89,
  parameter logic [N-1:0] G          = 8'd3,
  parameter logic [N-1:0] SEED       = 8'hA5,
  parameter logic [N-1:0] FIXED_PRIV = 8'd0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         gen_start,
  input  logic [N-1:0] peer_pub,
  input  logic         peer_valid,
  output logic [N-1:0] pub_out,
  output logic         pub_valid,
  output logic [N-1:0] shared_out,
  output logic         shared_valid,
  output logic         busy,
  output logic         err,
  output logic         mp_start,
  output logic [N-1:0] mp_base,
  output logic [N-1:0] mp_exp,
  input  logic [N-1:0] mp_res,
  input  logic         mp_rdy
);

  localparam logic [N-1:0] ZERO      = {N{1'b0}};
  localparam logic [N-1:0] PEER_MIN  = {{(N-2){1'b0}}, 2'b10};
  localparam logic [N-1:0] PEER_MAX  = P - PEER_MIN;
  // Galois form of x^8 + x^6 + x^5 + x^4 + 1
  localparam logic [N-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GEN_KEY   = 3'd1,
    PUB_REQ   = 3'd2,
    PUB_WAIT  = 3'd3,
    WAIT_PEER = 3'd4,
    SH_REQ    = 3'd5,
    SH_WAIT   = 3'd6,
    DONE      = 3'd7
  } state_t;

  state_t       state_r;
  logic [N-1:0] lfsr_r;
  logic [N-1:0] priv_r;
  logic [N-1:0] cand_s;

  // One Galois LFSR step: shift right, fold the taps in when a one falls out.
  function automatic logic [N-1:0] lfsr_next(input logic [N-1:0] cur);
    logic [N-1:0] nxt;
    if (cur[0]) begin
      nxt = {1'b0, cur[N-1:1]} ^ LFSR_TAPS;
    end else begin
      nxt = {1'b0, cur[N-1:1]};
    end
    return nxt;
  endfunction

  // Small-subgroup guard: 0, 1 and P-1 (and anything >= P) are refused.
  function automatic logic peer_in_range(input logic [N-1:0] b);
    return (b >= PEER_MIN) && (b <= PEER_MAX);
  endfunction

  // Private-key candidate: the test hook if set, otherwise the LFSR draw with
  // the MSB cleared so the exponentiation unit sees a positive exponent.
  always_comb begin
    cand_s = ZERO;
    if (FIXED_PRIV != ZERO) begin
      cand_s = FIXED_PRIV;
    end else begin
      cand_s = {1'b0, lfsr_r[N-2:0]};
    end
  end

  // Free-running entropy source, frozen only by ena.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_r <= SEED;
    end else if (ena) begin
      lfsr_r <= lfsr_next(lfsr_r);
    end
  end

  // Exchange sequencer with registered outputs and operand hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      priv_r       <= ZERO;
      pub_out      <= ZERO;
      pub_valid    <= 1'b0;
      shared_out   <= ZERO;
      shared_valid <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
      mp_start     <= 1'b0;
      mp_base      <= ZERO;
      mp_exp       <= ZERO;
    end else if (ena) begin
      mp_start <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (gen_start) begin
            pub_valid    <= 1'b0;
            shared_valid <= 1'b0;
            err          <= 1'b0;
            busy         <= 1'b1;
            state_r      <= GEN_KEY;
          end
        end
        GEN_KEY: begin
          // A zero draw is useless as a key; try again on the next LFSR value.
          if (cand_s != ZERO) begin
            priv_r   <= cand_s;
            mp_start <= 1'b1;
            mp_base  <= G;
            mp_exp   <= cand_s;
            state_r  <= PUB_REQ;
          end
        end
        PUB_REQ: begin
          state_r <= PUB_WAIT;
        end
        PUB_WAIT: begin
          if (mp_rdy) begin
            pub_out   <= mp_res;
            pub_valid <= 1'b1;
            state_r   <= WAIT_PEER;
          end
        end
        WAIT_PEER: begin
          if (peer_valid) begin
            if (peer_in_range(peer_pub)) begin
              mp_start <= 1'b1;
              mp_base  <= peer_pub;
              mp_exp   <= priv_r;
              state_r  <= SH_REQ;
            end else begin
              err     <= 1'b1;
              priv_r  <= ZERO;
              mp_exp  <= ZERO;
              busy    <= 1'b0;
              state_r <= DONE;
            end
          end
        end
        SH_REQ: begin
          state_r <= SH_WAIT;
        end
        SH_WAIT: begin
          if (mp_rdy) begin
            shared_out   <= mp_res;
            shared_valid <= 1'b1;
            priv_r       <= ZERO;
            mp_exp       <= ZERO;
            busy         <= 1'b0;
            state_r      <= DONE;
          end
        end
        default: begin
          priv_r  <= ZERO;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dh_key_agreement.sv
// Bench for dh_key_agreement: two instances (fixed key 5, and LFSR draw with a
// seed whose first draw masks to zero), a behavioural exponentiation unit, a
// transaction-level reference model and a per-cycle compare process.
module tb_dh_key_agreement;

  localparam logic [7:0] P_MOD   = 8'd89;
  localparam logic [7:0] G_GEN   = 8'd3;
  localparam logic [7:0] FIXED_A = 8'd5;
  localparam logic [7:0] SEED_B  = 8'h71;
  localparam int         LAT     = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;

  logic       gen_start_a  = 1'b0;
  logic       peer_valid_a = 1'b0;
  logic [7:0] peer_pub_a   = 8'd0;
  logic [7:0] pub_out_a, shared_out_a, mp_base_a, mp_exp_a;
  logic       pub_valid_a, shared_valid_a, busy_a, err_a, mp_start_a;

  logic       gen_start_b  = 1'b0;
  logic       peer_valid_b = 1'b0;
  logic [7:0] peer_pub_b   = 8'd0;
  logic [7:0] pub_out_b, shared_out_b, mp_base_b, mp_exp_b;
  logic       pub_valid_b, shared_valid_b, busy_b, err_b, mp_start_b;

  // behavioural exponentiation units, one per instance
  logic       u_start [2];
  logic [7:0] u_base  [2];
  logic [7:0] u_exp   [2];
  logic [7:0] u_res   [2] = '{8'd0, 8'd0};
  logic       u_rdy   [2] = '{1'b0, 1'b0};
  logic       u_sd    [2] = '{1'b0, 1'b0};
  int         u_cnt   [2] = '{0, 0};
  logic [7:0] u_b     [2] = '{8'd0, 8'd0};
  logic [7:0] u_e     [2] = '{8'd0, 8'd0};

  int n_checks = 0;
  int n_err    = 0;

  // reference model state for instance A
  int m_phase = 0;
  int m_priv  = 0;
  int m_b     = 0;
  int m_pub   = 0;
  int m_sh    = 0;
  int m_pubv  = 0;
  int m_shv   = 0;
  int m_err   = 0;

  assign u_start[0] = mp_start_a;
  assign u_start[1] = mp_start_b;
  assign u_base[0]  = mp_base_a;
  assign u_base[1]  = mp_base_b;
  assign u_exp[0]   = mp_exp_a;
  assign u_exp[1]   = mp_exp_b;

  always #5 clk = ~clk;

  dh_key_agreement #(.N(8), .P(P_MOD), .G(G_GEN), .SEED(8'hA5), .FIXED_PRIV(FIXED_A)) dut_a (
    .clk(clk), .rst(rst), .ena(ena), .gen_start(gen_start_a),
    .peer_pub(peer_pub_a), .peer_valid(peer_valid_a),
    .pub_out(pub_out_a), .pub_valid(pub_valid_a),
    .shared_out(shared_out_a), .shared_valid(shared_valid_a),
    .busy(busy_a), .err(err_a), .mp_start(mp_start_a),
    .mp_base(mp_base_a), .mp_exp(mp_exp_a), .mp_res(u_res[0]), .mp_rdy(u_rdy[0]));

  dh_key_agreement #(.N(8), .P(P_MOD), .G(G_GEN), .SEED(SEED_B), .FIXED_PRIV(8'd0)) dut_b (
    .clk(clk), .rst(rst), .ena(ena), .gen_start(gen_start_b),
    .peer_pub(peer_pub_b), .peer_valid(peer_valid_b),
    .pub_out(pub_out_b), .pub_valid(pub_valid_b),
    .shared_out(shared_out_b), .shared_valid(shared_valid_b),
    .busy(busy_b), .err(err_b), .mp_start(mp_start_b),
    .mp_base(mp_base_b), .mp_exp(mp_exp_b), .mp_res(u_res[1]), .mp_rdy(u_rdy[1]));

  function automatic int modpow(input int b, input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = (r * (b % int'(P_MOD))) % int'(P_MOD);
    return r;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    logic [7:0] n;
    n = v >> 1;
    if (v[0]) n = n ^ 8'hB8;
    return n;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // unit: samples operands one cycle after start, answers LAT cycles later
  always @(posedge clk) begin
    if (ena) begin
      for (int u = 0; u < 2; u++) begin
        u_rdy[u] <= 1'b0;
        u_sd[u]  <= u_start[u];
        if (u_sd[u]) begin
          u_cnt[u] <= LAT;
          u_b[u]   <= u_base[u];
          u_e[u]   <= u_exp[u];
        end else if (u_cnt[u] != 0) begin
          u_cnt[u] <= u_cnt[u] - 1;
          if (u_cnt[u] == 1) begin
            u_res[u] <= 8'(modpow(int'(u_b[u]), int'(u_e[u])));
            u_rdy[u] <= 1'b1;
          end
        end
      end
    end
  end

  // reference model of instance A (phases: 0 idle/done, 1 key, 2 pub req,
  // 3 pub wait, 4 peer wait, 5 shared req, 6 shared wait)
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_priv <= 0; m_b <= 0; m_pub <= 0;
      m_sh <= 0; m_pubv <= 0; m_shv <= 0; m_err <= 0;
    end else if (ena) begin
      case (m_phase)
        0: if (gen_start_a) begin
             m_phase <= 1; m_pubv <= 0; m_shv <= 0; m_err <= 0;
           end
        1: begin m_priv <= int'(FIXED_A); m_phase <= 2; end
        2: m_phase <= 3;
        3: if (u_rdy[0]) begin
             m_pub <= modpow(int'(G_GEN), m_priv); m_pubv <= 1; m_phase <= 4;
           end
        4: if (peer_valid_a) begin
             if (int'(peer_pub_a) >= 2 && int'(peer_pub_a) <= int'(P_MOD) - 2) begin
               m_b <= int'(peer_pub_a); m_phase <= 5;
             end else begin
               m_err <= 1; m_priv <= 0; m_phase <= 0;
             end
           end
        5: m_phase <= 6;
        6: if (u_rdy[0]) begin
             m_sh <= modpow(m_b, m_priv); m_shv <= 1; m_priv <= 0; m_phase <= 0;
           end
        default: m_phase <= 0;
      endcase
    end
  end

  // compare instance A against the model every cycle
  always @(negedge clk) begin
    check("pub_valid", pub_valid_a, m_pubv);
    check("pub_out", pub_out_a, m_pub);
    check("shared_valid", shared_valid_a, m_shv);
    check("shared_out", shared_out_a, m_sh);
    check("err", err_a, m_err);
    check("busy", busy_a, int'(m_phase != 0));
    check("mp_start", mp_start_a, int'(m_phase == 2 || m_phase == 5));
    check("priv", dut_a.priv_r, m_priv);
    if (m_phase == 2 || m_phase == 3) begin
      check("hold_pub_base", mp_base_a, int'(G_GEN));
      check("hold_pub_exp", mp_exp_a, m_priv);
    end
    if (m_phase == 5 || m_phase == 6) begin
      check("hold_sh_base", mp_base_a, m_b);
      check("hold_sh_exp", mp_exp_a, m_priv);
    end
  end

  task automatic wait_flag(input int which, input int max);
    int  n = 0;
    bit  hit = 1'b0;
    while (!hit && n < max) begin
      @(negedge clk);
      n++;
      case (which)
        0:       hit = pub_valid_a;
        1:       hit = shared_valid_a;
        default: hit = pub_valid_b;
      endcase
    end
    check("wait_timeout", int'(hit), 1);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_pub_out"}, pub_out_a, 0);
    check({tag, "_pub_valid"}, pub_valid_a, 0);
    check({tag, "_shared_out"}, shared_out_a, 0);
    check({tag, "_shared_valid"}, shared_valid_a, 0);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_err"}, err_a, 0);
    check({tag, "_mp_start"}, mp_start_a, 0);
    check({tag, "_mp_base"}, mp_base_a, 0);
    check({tag, "_mp_exp"}, mp_exp_a, 0);
    check({tag, "_priv"}, dut_a.priv_r, 0);
  endtask

  // mode 0 plain, 1 stray pulses in PUB_WAIT, 2 ena pause in SH_WAIT, 3 rst in SH_WAIT
  task automatic run_a(input logic [7:0] b, input int exp_err, input int exp_sh, input int mode);
    @(negedge clk); gen_start_a = 1'b1;
    @(negedge clk); gen_start_a = 1'b0;
    check("gen_busy", busy_a, 1);
    @(negedge clk);
    check("pub_start_cycle2", mp_start_a, 1);
    @(negedge clk);
    if (mode == 1) begin
      gen_start_a = 1'b1; peer_valid_a = 1'b1; peer_pub_a = 8'd10;
      @(negedge clk);
      gen_start_a = 1'b0; peer_valid_a = 1'b0;
    end
    wait_flag(0, 40);
    check("pub_out_65", pub_out_a, 65);
    check("pub_busy", busy_a, 1);
    peer_pub_a = b; peer_valid_a = 1'b1;
    @(negedge clk);
    peer_valid_a = 1'b0;
    check("peer_err", err_a, exp_err);
    if (exp_err != 0) begin
      check("rej_busy", busy_a, 0);
      check("rej_shared_valid", shared_valid_a, 0);
      check("rej_priv", dut_a.priv_r, 0);
      repeat (8) @(negedge clk);
    end else begin
      @(negedge clk);
      @(negedge clk);
      if (mode == 2) begin
        ena = 1'b0;
        repeat (10) @(negedge clk);
        check("pause_shared_valid", shared_valid_a, 0);
        ena = 1'b1;
      end
      if (mode == 3) begin
        #2 rst = 1'b1;
        #1 check_reset_a("async_rst");
        @(negedge clk); rst = 1'b0;
        repeat (10) @(negedge clk);
        check("post_rst_shared_valid", shared_valid_a, 0);
        check("post_rst_busy", busy_a, 0);
      end else begin
        wait_flag(1, 40);
        check("shared_out", shared_out_a, exp_sh);
        check("done_busy", busy_a, 0);
        check("done_priv", dut_a.priv_r, 0);
        repeat (3) @(negedge clk);
      end
    end
  endtask

  initial begin
    int         k;
    int         draws;
    logic [7:0] v;
    logic [7:0] exp_priv_b;

    repeat (3) @(negedge clk);
    check_reset_a("reset");
    check("reset_b_busy", busy_b, 0);
    check("reset_b_lfsr", dut_b.lfsr_r, int'(SEED_B));

    // expected LFSR draw for instance B
    v = lfsr_step(SEED_B);
    draws = 1;
    while ((v & 8'h7F) == 8'h00) begin
      v = lfsr_step(v);
      draws++;
    end
    exp_priv_b = v & 8'h7F;

    rst = 1'b0; gen_start_b = 1'b1;
    @(negedge clk); gen_start_b = 1'b0;
    check("b_busy", busy_b, 1);
    k = 0;
    while (!mp_start_b && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("b_gen_cycles", k, draws);
    check("b_gen_cycles_2", k, 2);
    check("b_priv_model", mp_exp_b, int'(exp_priv_b));
    check("b_priv_64", mp_exp_b, 64);
    check("b_priv_msb", int'(mp_exp_b[7]), 0);
    check("b_base", mp_base_b, int'(G_GEN));
    wait_flag(2, 40);
    check("b_pub_model", pub_out_b, modpow(int'(G_GEN), int'(exp_priv_b)));
    check("b_pub_16", pub_out_b, 16);

    run_a(8'd10, 0, 53, 1);
    run_a(8'd88, 1, 0, 0);
    run_a(8'd1,  1, 0, 0);
    run_a(8'd87, 0, 57, 0);
    run_a(8'd2,  0, 32, 0);
    run_a(8'd10, 0, 53, 2);
    run_a(8'd10, 0, 0, 3);
    run_a(8'd10, 0, 53, 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
